// File: rtl/acoustics_trig_pkg.sv
// Shared definitions for the acoustic trigger qualifier slice: state encoding
// and the widths of the magnitude, bin and hit-count fields.
package acoustics_trig_pkg;

    localparam int MAG_W    = 16;
    localparam int BIN_W    = 8;
    localparam int HITCNT_W = 4;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FIRE     = 2'd2,
        HOLDOFF  = 2'd3
    } trigState_e;

endpackage

// File: rtl/trig_holdoff_timer.sv
// Holdoff down-counter: loads HOLDOFF_CYCLES-1, decrements on request and
// reports when it has reached zero.
module trig_holdoff_timer #(
    parameter int HOLDOFF_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLDOFF_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load takes priority; a decrement never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/trigger_qualifier.sv
// Trigger qualifier: turns raw per-beat detector triggers into one qualified,
// timestamped event per ping after REQ_FRAMES consecutive hit frames, then
// suppresses re-triggering for a holdoff window.
// Optional feature macro: TRIG_PEAK_CAPTURE_EN (peak magnitude/bin capture of
// the firing frame). Without it peak_mag_o/peak_bin_o are tied to zero.
module trigger_qualifier
    import acoustics_trig_pkg::*;
#(
    parameter int REQ_FRAMES     = 3,
    parameter int HOLDOFF_CYCLES = 1000000,
    parameter int TS_WIDTH       = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                arm_i,
    input  logic                beat_valid_i,
    input  logic                trig_in_i,
    input  logic                frame_end_i,
    input  logic [MAG_W-1:0]    mag_in_i,
    input  logic [BIN_W-1:0]    bin_in_i,
    output logic                trig_out_o,
    output logic [TS_WIDTH-1:0] trig_ts_o,
    output logic                busy_o,
    output logic [HITCNT_W-1:0] hit_count_o,
    output logic [MAG_W-1:0]    peak_mag_o,
    output logic [BIN_W-1:0]    peak_bin_o
);

    localparam logic [HITCNT_W-1:0] REQ_COUNT = HITCNT_W'(REQ_FRAMES);

    trigState_e state_q;
    trigState_e state_d;

    logic [HITCNT_W-1:0] hitCount_q;
    logic [HITCNT_W-1:0] hitCount_d;
    logic                hitFlag_q;
    logic                hitFlag_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_d;
    logic [TS_WIDTH-1:0] trigTs_q;
    logic [TS_WIDTH-1:0] trigTs_d;

    logic                beatTrig;
    logic                frameHit;
    logic [HITCNT_W-1:0] hitInc;
    logic                fireNow;
    logic                timerLoad;
    logic                timerDec;
    logic                timerZero;

    // A trigger on the frame_end beat still belongs to the frame that ends.
    assign beatTrig = beat_valid_i & trig_in_i;
    assign frameHit = hitFlag_q | beatTrig;
    assign hitInc   = hitCount_q + HITCNT_W'(1);
    assign fireNow  = (state_q == ARMED) & arm_i & frame_end_i & frameHit
                      & (hitInc == REQ_COUNT);

    trig_holdoff_timer #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) uHoldoffTimer (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (timerLoad),
        .dec_i  (timerDec),
        .zero_o (timerZero)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: disarm is immediate only in ARMED; FIRE and HOLDOFF always run to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DISARMED: if (arm_i) state_d = ARMED;
            ARMED: begin
                if (!arm_i) begin
                    state_d = DISARMED;
                end else if (fireNow) begin
                    state_d = FIRE;
                end
            end
            FIRE:     state_d = HOLDOFF;
            HOLDOFF: begin
                if (timerZero) begin
                    state_d = arm_i ? ARMED : DISARMED;
                end
            end
            default:  state_d = DISARMED;
        endcase
    end

    // FSM outputs: pulse in FIRE, busy plus timer countdown in HOLDOFF.
    always_comb begin
        trig_out_o = 1'b0;
        busy_o     = 1'b0;
        timerLoad  = 1'b0;
        timerDec   = 1'b0;
        case (state_q)
            FIRE:    begin
                trig_out_o = 1'b1;
                timerLoad  = 1'b1;
            end
            HOLDOFF: begin
                busy_o   = 1'b1;
                timerDec = !timerZero;
            end
            default: ;
        endcase
    end

    // Hit flag, hit count, free-running timestamp and event timestamp next-state.
    always_comb begin
        ts_d       = ts_q + TS_WIDTH'(1);
        hitCount_d = hitCount_q;
        hitFlag_d  = hitFlag_q;
        trigTs_d   = trigTs_q;
        case (state_q)
            ARMED: begin
                if (!arm_i) begin
                    hitCount_d = '0;
                    hitFlag_d  = 1'b0;
                end else if (frame_end_i) begin
                    hitCount_d = frameHit ? hitInc : '0;
                    hitFlag_d  = 1'b0;
                end else if (beatTrig) begin
                    hitFlag_d  = 1'b1;
                end
            end
            default: begin
                hitCount_d = '0;
                hitFlag_d  = 1'b0;
            end
        endcase
        if (fireNow) begin
            trigTs_d = ts_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q       <= '0;
            hitCount_q <= '0;
            hitFlag_q  <= 1'b0;
            trigTs_q   <= '0;
        end else begin
            ts_q       <= ts_d;
            hitCount_q <= hitCount_d;
            hitFlag_q  <= hitFlag_d;
            trigTs_q   <= trigTs_d;
        end
    end

    assign trig_ts_o   = trigTs_q;
    assign hit_count_o = hitCount_q;

`ifdef TRIG_PEAK_CAPTURE_EN
    logic [MAG_W-1:0] curMag_q;
    logic [MAG_W-1:0] curMag_d;
    logic [BIN_W-1:0] curBin_q;
    logic [BIN_W-1:0] curBin_d;
    logic             curValid_q;
    logic             curValid_d;
    logic [MAG_W-1:0] candMag;
    logic [BIN_W-1:0] candBin;
    logic [MAG_W-1:0] peakMag_q;
    logic [MAG_W-1:0] peakMag_d;
    logic [BIN_W-1:0] peakBin_q;
    logic [BIN_W-1:0] peakBin_d;

    // Running frame maximum including the current beat; strict compare keeps the first bin on ties.
    always_comb begin
        candMag    = curMag_q;
        candBin    = curBin_q;
        if (beat_valid_i && (!curValid_q || (mag_in_i > curMag_q))) begin
            candMag = mag_in_i;
            candBin = bin_in_i;
        end
        curMag_d   = curMag_q;
        curBin_d   = curBin_q;
        curValid_d = curValid_q;
        if (frame_end_i) begin
            curValid_d = 1'b0;
        end else if (beat_valid_i) begin
            curMag_d   = candMag;
            curBin_d   = candBin;
            curValid_d = 1'b1;
        end
        peakMag_d  = peakMag_q;
        peakBin_d  = peakBin_q;
        if (fireNow) begin
            peakMag_d = candMag;
            peakBin_d = candBin;
        end
    end

    // Peak tracker and captured-peak registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            curMag_q   <= '0;
            curBin_q   <= '0;
            curValid_q <= 1'b0;
            peakMag_q  <= '0;
            peakBin_q  <= '0;
        end else begin
            curMag_q   <= curMag_d;
            curBin_q   <= curBin_d;
            curValid_q <= curValid_d;
            peakMag_q  <= peakMag_d;
            peakBin_q  <= peakBin_d;
        end
    end

    assign peak_mag_o = peakMag_q;
    assign peak_bin_o = peakBin_q;
`else
    logic unusedPeakInputs;
    assign unusedPeakInputs = ^{mag_in_i, bin_in_i};
    assign peak_mag_o       = '0;
    assign peak_bin_o       = '0;
`endif

endmodule

// File: tb/tb_trigger_qualifier.sv
// Self-checking bench for trigger_qualifier (REQ_FRAMES=3, HOLDOFF_CYCLES=50).
// Qualified events are predicted into a queue when the qualifying frame_end is
// driven and are popped by a monitor whenever trig_out is seen.
module tb_trigger_qualifier;

    localparam int REQ  = 3;
    localparam int HOLD = 50;
    localparam int TSW  = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           arm;
    logic           beatValid;
    logic           trigIn;
    logic           frameEnd;
    logic [15:0]    magIn;
    logic [7:0]     binIn;
    logic           trigOut;
    logic [TSW-1:0] trigTs;
    logic           busy;
    logic [3:0]     hitCount;
    logic [15:0]    peakMag;
    logic [7:0]     peakBin;

    typedef struct {
        logic [TSW-1:0] ts;
        int             cyc;
        logic [15:0]    mag;
        logic [7:0]     bin;
    } expEvent_t;

    expEvent_t   expQ[$];
    int          passCount  = 0;
    int          checkCount = 0;
    int          tbCycle;
    int          busyCount;
    logic [15:0] frameMag[8];
    logic [7:0]  frameBin[8];

    trigger_qualifier #(
        .REQ_FRAMES    (REQ),
        .HOLDOFF_CYCLES(HOLD),
        .TS_WIDTH      (TSW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .arm_i       (arm),
        .beat_valid_i(beatValid),
        .trig_in_i   (trigIn),
        .frame_end_i (frameEnd),
        .mag_in_i    (magIn),
        .bin_in_i    (binIn),
        .trig_out_o  (trigOut),
        .trig_ts_o   (trigTs),
        .busy_o      (busy),
        .hit_count_o (hitCount),
        .peak_mag_o  (peakMag),
        .peak_bin_o  (peakBin)
    );

    always #5 clk = ~clk;

    // Bench view of the free-running timestamp: posedges since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) tbCycle <= 0;
        else       tbCycle <= tbCycle + 1;
    end

    // Scoreboard monitor: every trig_out pulse must match the oldest prediction.
    always @(negedge clk) begin : monitor
        expEvent_t e;
        if (!reset && trigOut === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_trig: trig_out=1 at cycle %0d, required no pulse", tbCycle);
            end else begin
                e = expQ.pop_front();
                checkCount++;
                if (tbCycle !== e.cyc)
                    $display("[TB] FAIL trig_latency: pulse at cycle %0d, required %0d", tbCycle, e.cyc);
                else passCount++;
                checkCount++;
                if (trigTs !== e.ts)
                    $display("[TB] FAIL trig_ts: got %0d, required %0d", trigTs, e.ts);
                else passCount++;
                checkCount++;
                if (peakMag !== e.mag || peakBin !== e.bin)
                    $display("[TB] FAIL peak: got mag %0d bin %0d, required mag %0d bin %0d",
                             peakMag, peakBin, e.mag, e.bin);
                else passCount++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_default_frame();
        for (int b = 0; b < 8; b++) begin
            frameMag[b] = 16'd0;
            frameBin[b] = 8'(b);
        end
    endtask

    // One frame of nBeats back-to-back beats followed by one idle cycle.
    task automatic drive_frame(input int nBeats, input int hitMask, input bit expectFire,
                               input logic [15:0] expMag, input logic [7:0] expBin);
        expEvent_t e;
        for (int b = 0; b < nBeats; b++) begin
            @(negedge clk);
            beatValid = 1'b1;
            trigIn    = hitMask[b];
            frameEnd  = (b == nBeats - 1);
            magIn     = frameMag[b];
            binIn     = frameBin[b];
            if (busy) busyCount++;
            if (frameEnd && expectFire) begin
                e.ts  = TSW'(tbCycle);
                e.cyc = tbCycle + 1;
                e.mag = expMag;
                e.bin = expBin;
                expQ.push_back(e);
            end
        end
        @(negedge clk);
        beatValid = 1'b0;
        trigIn    = 1'b0;
        frameEnd  = 1'b0;
        magIn     = 16'd0;
        binIn     = 8'd0;
        if (busy) busyCount++;
    endtask

    task automatic wait_holdoff_end(input string name);
        int  n    = 0;
        bit  seen = 0;
        bit  done = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (busy) seen = 1;
            else if (seen) done = 1;
        end
        checkCount++;
        if (!done) $display("[TB] FAIL %s_holdoff_timeout: busy seen=%0d, required a full holdoff", name, seen);
        else passCount++;
    endtask

    task automatic check_drained(input string name);
        checkCount++;
        if (expQ.size() !== 0)
            $display("[TB] FAIL %s_missing_trig: %0d predicted pulses pending, required 0", name, expQ.size());
        else passCount++;
    endtask

    task automatic check_count(input string name, input logic [3:0] required);
        checkCount++;
        if (hitCount !== required)
            $display("[TB] FAIL %s: hit_count=%0d, required %0d", name, hitCount, required);
        else passCount++;
    endtask

    task automatic rearm();
        @(negedge clk); arm = 1'b0;
        @(negedge clk); arm = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; beatValid = 1'b0; trigIn = 1'b0; frameEnd = 1'b0;
        magIn = 16'd0; binIn = 8'd0;
        set_default_frame();
        repeat (3) @(negedge clk);
        checkCount++;
        if (trigOut !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL reset_ctrl: trig_out=%b busy=%b, required 0 0", trigOut, busy);
        else passCount++;
        check_count("reset_hit_count", 4'd0);
        checkCount++;
        if (trigTs !== '0) $display("[TB] FAIL reset_trig_ts: got %0d, required 0", trigTs);
        else passCount++;
        checkCount++;
        if (peakMag !== 16'd0 || peakBin !== 8'd0) $display("[TB] FAIL reset_peak: got %0d/%0d, required 0/0", peakMag, peakBin);
        else passCount++;
        reset = 1'b0;
        @(negedge clk); arm = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [TSW-1:0] firedTs;
        drive_frame(4, 'b0010, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0100, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0001, 1, 16'd0, 8'd0);
        checkCount++;
        if (trigOut !== 1'b1) $display("[TB] FAIL basic_pulse: trig_out=%b, required 1", trigOut);
        else passCount++;
        check_count("basic_count_at_fire", 4'(REQ));
        firedTs = trigTs;
        wait_holdoff_end("basic");
        check_drained("basic");
        checkCount++;
        if (trigTs !== firedTs) $display("[TB] FAIL basic_ts_hold: got %0d, required %0d", trigTs, firedTs);
        else passCount++;
    endtask

    task automatic test_miss_resets();
        int hitSeq[5] = '{1, 1, 0, 1, 1};
        int expSeq[5] = '{1, 2, 0, 1, 2};
        for (int i = 0; i < 5; i++) begin
            drive_frame(4, hitSeq[i] != 0 ? 'b0110 : 'b0000, 0, 16'd0, 8'd0);
            check_count($sformatf("miss_seq%0d", i), 4'(expSeq[i]));
        end
        check_drained("miss");
        rearm();
    endtask

    task automatic test_holdoff();
        drive_frame(4, 'b1111, 0, 16'd0, 8'd0);
        drive_frame(4, 'b1111, 0, 16'd0, 8'd0);
        drive_frame(4, 'b1111, 1, 16'd0, 8'd0);
        busyCount = 0;
        for (int f = 0; f < 10; f++) drive_frame(4, 'b1111, 0, 16'd0, 8'd0);
        drive_frame(4, 'b1111, 0, 16'd0, 8'd0);
        check_count("holdoff_first_frame_after", 4'd1);
        drive_frame(4, 'b1111, 0, 16'd0, 8'd0);
        check_count("holdoff_second_frame_after", 4'd2);
        checkCount++;
        if (busyCount !== HOLD) $display("[TB] FAIL holdoff_busy_len: busy for %0d cycles, required %0d", busyCount, HOLD);
        else passCount++;
        drive_frame(4, 'b1111, 1, 16'd0, 8'd0);
        wait_holdoff_end("holdoff");
        check_drained("holdoff");
    endtask

    task automatic test_end_beat();
        drive_frame(4, 'b1000, 0, 16'd0, 8'd0);
        check_count("endbeat_count", 4'd1);
        drive_frame(4, 'b1000, 0, 16'd0, 8'd0);
        drive_frame(4, 'b1000, 1, 16'd0, 8'd0);
        wait_holdoff_end("endbeat");
        check_drained("endbeat");
    endtask

    task automatic test_arm_drop();
        drive_frame(4, 'b0001, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0001, 0, 16'd0, 8'd0);
        check_count("armdrop_before", 4'd2);
        @(negedge clk); arm = 1'b0;
        @(negedge clk);
        check_count("armdrop_cleared", 4'd0);
        arm = 1'b1;
        @(negedge clk);
        drive_frame(4, 'b0001, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0001, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0001, 1, 16'd0, 8'd0);
        @(negedge clk); arm = 1'b0;
        wait_holdoff_end("armdrop");
        drive_frame(4, 'b1111, 0, 16'd0, 8'd0);
        check_count("armdrop_disarmed_after_holdoff", 4'd0);
        check_drained("armdrop");
        arm = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_holdoff();
        drive_frame(4, 'b0010, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0010, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0010, 1, 16'd0, 8'd0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkCount++;
        if (busy !== 1'b0 || trigTs !== '0 || hitCount !== 4'd0)
            $display("[TB] FAIL async_reset: busy=%b trig_ts=%0d hit_count=%0d, required 0 0 0", busy, trigTs, hitCount);
        else passCount++;
        check_drained("async_reset");
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        drive_frame(2, 'b01, 0, 16'd0, 8'd0);
        check_count("partial_frame", 4'd1);
        drive_frame(4, 'b0100, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0100, 1, 16'd0, 8'd0);
        wait_holdoff_end("post_reset");
        check_drained("post_reset");
    endtask

    task automatic test_peak();
        logic [15:0] expMag;
        logic [7:0]  expBin;
`ifdef TRIG_PEAK_CAPTURE_EN
        expMag = 16'd900;
        expBin = 8'd17;
`else
        expMag = 16'd0;
        expBin = 8'd0;
`endif
        drive_frame(4, 'b0001, 0, 16'd0, 8'd0);
        drive_frame(4, 'b0001, 0, 16'd0, 8'd0);
        frameMag[0] = 16'd100; frameBin[0] = 8'd16;
        frameMag[1] = 16'd900; frameBin[1] = 8'd17;
        frameMag[2] = 16'd900; frameBin[2] = 8'd18;
        frameMag[3] = 16'd50;  frameBin[3] = 8'd19;
        drive_frame(4, 'b0001, 1, expMag, expBin);
        set_default_frame();
        wait_holdoff_end("peak");
        check_drained("peak");
        checkCount++;
        if (peakMag !== expMag || peakBin !== expBin)
            $display("[TB] FAIL peak_hold: got %0d/%0d, required %0d/%0d", peakMag, peakBin, expMag, expBin);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_miss_resets();
        test_holdoff();
        test_end_beat();
        test_arm_drop();
        test_reset_mid_holdoff();
        test_peak();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
